// File: rtl/b2t_slew.sv
// b2t_slew: slew-rate-limited binary counter with a registered thermometer output.
// A target count is accepted over a valid/ready handshake. The current count
// then ramps toward it by at most STEP per tick. With B2T_SLEW_SETTLE_EN
// defined, the block holds for SETTLE_CYC cycles before signalling done.
//
// Parameters:
//   BIN_W      - binary code width
//   STEP       - maximum count change per tick (1..2**BIN_W-1)
//   SETTLE_CYC - settle hold in clk cycles (>=1); used only with the macro
// Ports:
//   clk        - clock; all logic is rising-edge
//   rst_n      - asynchronous active-low reset
//   tick       - slew-rate strobe
//   tgt_valid  - a new target is presented
//   tgt_ready  - the block can accept a target (IDLE/SETTLE)
//   tgt_bin    - target count
//   cur_bin    - current registered count
//   thermo     - registered thermometer code of cur_bin
//   busy       - high whenever the state is not IDLE
//   done       - one-cycle registered pulse when the target is reached
module b2t_slew #(
    parameter int BIN_W      = 4,
    parameter int STEP       = 1,
    parameter int SETTLE_CYC = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  tick,
    input  logic                  tgt_valid,
    output logic                  tgt_ready,
    input  logic [BIN_W-1:0]      tgt_bin,
    output logic [BIN_W-1:0]      cur_bin,
    output logic [(2**BIN_W)-1:0] thermo,
    output logic                  busy,
    output logic                  done
);

    localparam int THERM_W = 2**BIN_W;

    localparam logic [BIN_W:0]   STEP_X = (BIN_W+1)'(STEP);
    localparam logic [BIN_W-1:0] STEP_B = BIN_W'(STEP);

`ifdef B2T_SLEW_SETTLE_EN
    localparam int CNT_W = $clog2(SETTLE_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYC - 1);

    typedef enum logic [1:0] {IDLE, SLEW, SETTLE} state_t;

    logic [CNT_W-1:0] cnt_q, cnt_d;
`else
    typedef enum logic [1:0] {IDLE, SLEW} state_t;
`endif

    state_t               state_q, state_d;
    logic [BIN_W-1:0]     cur_q, cur_d;
    logic [BIN_W-1:0]     tgt_q, tgt_d;
    logic [THERM_W-1:0]   thermo_q, thermo_d;
    logic                 busy_q, busy_d;
    logic                 done_q, done_d;

    logic                 xfer;
    logic signed [BIN_W:0] diff;
    logic [BIN_W:0]       mag;
    logic [BIN_W-1:0]     nxt;

    assign tgt_ready = (state_q != SLEW);
    assign xfer      = tgt_valid & tgt_ready;

    // One extra bit keeps the difference free of wrap-around at both ends.
    always_comb begin
        diff = $signed({1'b0, tgt_q}) - $signed({1'b0, cur_q});
        mag  = diff[BIN_W] ? (~diff + 1'b1) : diff;
        if (mag > STEP_X) begin
            nxt = diff[BIN_W] ? (cur_q - STEP_B) : (cur_q + STEP_B);
        end else begin
            nxt = tgt_q;
        end
    end

    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        tgt_d   = tgt_q;
        done_d  = 1'b0;
`ifdef B2T_SLEW_SETTLE_EN
        cnt_d   = cnt_q;
`endif
        unique case (state_q)
            IDLE: begin
                if (xfer) begin
                    tgt_d = tgt_bin;
                    if (tgt_bin != cur_q) state_d = SLEW;
                    else                  done_d  = 1'b1;
                end
            end
            SLEW: begin
                if (tick) begin
                    cur_d = nxt;
                    if (nxt == tgt_q) begin
`ifdef B2T_SLEW_SETTLE_EN
                        state_d = SETTLE;
                        cnt_d   = '0;
`else
                        state_d = IDLE;
                        done_d  = 1'b1;
`endif
                    end
                end
            end
`ifdef B2T_SLEW_SETTLE_EN
            SETTLE: begin
                // A new target abandons the current settle without a pulse.
                if (xfer) begin
                    tgt_d = tgt_bin;
                    cnt_d = '0;
                    if (tgt_bin != cur_q) begin
                        state_d = SLEW;
                    end else begin
                        state_d = IDLE;
                        done_d  = 1'b1;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // Thermometer of the next count, registered alongside it.
    assign thermo_d = (THERM_W'(1) << cur_d) - THERM_W'(1);
    assign busy_d   = (state_d != IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cur_q    <= '0;
            tgt_q    <= '0;
            thermo_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
`ifdef B2T_SLEW_SETTLE_EN
            cnt_q    <= '0;
`endif
        end else begin
            state_q  <= state_d;
            cur_q    <= cur_d;
            tgt_q    <= tgt_d;
            thermo_q <= thermo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
`ifdef B2T_SLEW_SETTLE_EN
            cnt_q    <= cnt_d;
`endif
        end
    end

    assign cur_bin = cur_q;
    assign thermo  = thermo_q;
    assign busy    = busy_q;
    assign done    = done_q;

endmodule

// File: tb/tb_b2t_slew.sv
// tb_b2t_slew: directed bench for b2t_slew, three instances (STEP 1, 3, 15)
// sharing stimulus; one task per scenario with inline expectations.
module tb_b2t_slew;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        tick;
    logic        tgt_valid;
    logic [3:0]  tgt_bin;

    logic [2:0]  tr, bz, dn;
    logic [3:0]  cb0, cb1, cb2;
    logic [15:0] th0, th1, th2;

    logic        ready_m, busy_m, done_m;
    logic [3:0]  cur_m;
    logic [15:0] th_m;

    int tests = 0;
    int fails = 0;
    int sel   = 0;

    logic [3:0] seq[$];
    int         dcnt;
    logic       b15;

    always #5 clk = ~clk;

    b2t_slew #(.BIN_W(4), .STEP(1), .SETTLE_CYC(4)) u_s1 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .tgt_valid(tgt_valid),
        .tgt_ready(tr[0]), .tgt_bin(tgt_bin), .cur_bin(cb0),
        .thermo(th0), .busy(bz[0]), .done(dn[0]));

    b2t_slew #(.BIN_W(4), .STEP(3), .SETTLE_CYC(4)) u_s3 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .tgt_valid(tgt_valid),
        .tgt_ready(tr[1]), .tgt_bin(tgt_bin), .cur_bin(cb1),
        .thermo(th1), .busy(bz[1]), .done(dn[1]));

    b2t_slew #(.BIN_W(4), .STEP(15), .SETTLE_CYC(4)) u_s15 (
        .clk(clk), .rst_n(rst_n), .tick(tick), .tgt_valid(tgt_valid),
        .tgt_ready(tr[2]), .tgt_bin(tgt_bin), .cur_bin(cb2),
        .thermo(th2), .busy(bz[2]), .done(dn[2]));

    always_comb begin
        ready_m = tr[0];
        busy_m  = bz[0];
        done_m  = dn[0];
        cur_m   = cb0;
        th_m    = th0;
        case (sel)
            1: begin
                ready_m = tr[1]; busy_m = bz[1]; done_m = dn[1];
                cur_m = cb1; th_m = th1;
            end
            2: begin
                ready_m = tr[2]; busy_m = bz[2]; done_m = dn[2];
                cur_m = cb2; th_m = th2;
            end
            default: ;
        endcase
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick = 1'b0;
        tgt_valid = 1'b0;
        tgt_bin = 4'd0;
        step();
        step();
        rst_n = 1'b1;
    endtask

    // Transfer t, then run ncyc cycles recording each new cur_bin value.
    task automatic go(input logic [3:0] t, input int ncyc);
        logic [3:0] prev;
        tgt_valid = 1'b1;
        tgt_bin = t;
        tick = 1'b1;
        step();
        tgt_valid = 1'b0;
        seq.delete();
        dcnt = 0;
        b15 = th_m[15];
        if (done_m) dcnt++;
        prev = cur_m;
        for (int i = 0; i < ncyc; i++) begin
            step();
            if (cur_m !== prev) seq.push_back(cur_m);
            prev = cur_m;
            if (done_m) dcnt++;
            if (th_m[15]) b15 = 1'b1;
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        tick = 1'b0;
        tgt_valid = 1'b0;
        tgt_bin = 4'd0;
        for (int s = 0; s < 3; s++) begin
            sel = s;
            #1;
            tests++;
            if (cur_m !== 4'd0) begin
                fails++; $display("FAIL rst_cur[%0d]: got %0d want 0", s, cur_m);
            end
            tests++;
            if (th_m !== 16'h0000) begin
                fails++; $display("FAIL rst_thermo[%0d]: got %h want 0000", s, th_m);
            end
            tests++;
            if (busy_m !== 1'b0 || done_m !== 1'b0) begin
                fails++;
                $display("FAIL rst_busy_done[%0d]: got %b%b want 00", s, busy_m, done_m);
            end
            tests++;
            if (ready_m !== 1'b1) begin
                fails++; $display("FAIL rst_ready[%0d]: got %b want 1", s, ready_m);
            end
        end
        sel = 0;
    endtask

    task automatic test_step1();
        logic [3:0] exp_s[5];
        exp_s = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd5};
        sel = 0;
        do_reset();
        go(4'd5, 25);
        tests++;
        if (seq.size() !== 5) begin
            fails++; $display("FAIL step1_len: got %0d want 5", seq.size());
        end
        for (int i = 0; i < 5; i++) begin
            if (i < seq.size()) begin
                tests++;
                if (seq[i] !== exp_s[i]) begin
                    fails++;
                    $display("FAIL step1_seq[%0d]: got %0d want %0d", i, seq[i], exp_s[i]);
                end
            end
        end
        tests++;
        if (th_m !== 16'h001F) begin
            fails++; $display("FAIL step1_thermo: got %h want 001f", th_m);
        end
        tests++;
        if (dcnt !== 1) begin
            fails++; $display("FAIL step1_done: got %0d pulses want 1", dcnt);
        end
        tests++;
        if (busy_m !== 1'b0 || ready_m !== 1'b1) begin
            fails++;
            $display("FAIL step1_idle: got busy=%b ready=%b want 0 1", busy_m, ready_m);
        end
    endtask

    task automatic test_step3();
        logic [3:0] up_s[3];
        logic [3:0] dn_s[2];
        up_s = '{4'd3, 4'd6, 4'd7};
        dn_s = '{4'd4, 4'd1};
        sel = 1;
        do_reset();
        go(4'd7, 25);
        tests++;
        if (seq.size() !== 3) begin
            fails++; $display("FAIL step3_up_len: got %0d want 3", seq.size());
        end
        for (int i = 0; i < 3; i++) begin
            if (i < seq.size()) begin
                tests++;
                if (seq[i] !== up_s[i]) begin
                    fails++;
                    $display("FAIL step3_up[%0d]: got %0d want %0d", i, seq[i], up_s[i]);
                end
            end
        end
        tests++;
        if (dcnt !== 1) begin
            fails++; $display("FAIL step3_up_done: got %0d want 1", dcnt);
        end
        go(4'd1, 25);
        tests++;
        if (seq.size() !== 2) begin
            fails++; $display("FAIL step3_dn_len: got %0d want 2", seq.size());
        end
        for (int i = 0; i < 2; i++) begin
            if (i < seq.size()) begin
                tests++;
                if (seq[i] !== dn_s[i]) begin
                    fails++;
                    $display("FAIL step3_dn[%0d]: got %0d want %0d", i, seq[i], dn_s[i]);
                end
            end
        end
        tests++;
        if (th_m !== 16'h0001) begin
            fails++; $display("FAIL step3_thermo: got %h want 0001", th_m);
        end
    endtask

    task automatic test_full_range();
        sel = 2;
        do_reset();
        go(4'd15, 25);
        tests++;
        if (seq.size() !== 1 || cur_m !== 4'd15) begin
            fails++;
            $display("FAIL full_up: got len=%0d cur=%0d want 1 15", seq.size(), cur_m);
        end
        tests++;
        if (th_m !== 16'h7FFF || b15 !== 1'b0) begin
            fails++; $display("FAIL full_up_thermo: got %h b15=%b want 7fff 0", th_m, b15);
        end
        go(4'd0, 25);
        tests++;
        if (th_m !== 16'h0000 || cur_m !== 4'd0) begin
            fails++; $display("FAIL full_dn: got %h cur=%0d want 0000 0", th_m, cur_m);
        end
        tests++;
        if (b15 !== 1'b0 || dcnt !== 1) begin
            fails++; $display("FAIL full_dn_b15: got b15=%b done=%0d want 0 1", b15, dcnt);
        end
    endtask

    task automatic test_equal_target();
        sel = 0;
        do_reset();
        tgt_valid = 1'b1;
        tgt_bin = 4'd0;
        step();
        tgt_valid = 1'b0;
        tests++;
        if (busy_m !== 1'b0 || done_m !== 1'b1) begin
            fails++;
            $display("FAIL eq_pulse: got busy=%b done=%b want 0 1", busy_m, done_m);
        end
        step();
        tests++;
        if (busy_m !== 1'b0 || done_m !== 1'b0) begin
            fails++;
            $display("FAIL eq_after: got busy=%b done=%b want 0 0", busy_m, done_m);
        end
    endtask

    task automatic test_hold_and_ignore();
        sel = 0;
        do_reset();
        tgt_valid = 1'b1;
        tgt_bin = 4'd3;
        tick = 1'b0;
        step();
        tgt_bin = 4'd9;
        step();
        step();
        step();
        tests++;
        if (cur_m !== 4'd0 || busy_m !== 1'b1 || ready_m !== 1'b0) begin
            fails++;
            $display("FAIL hold: got cur=%0d busy=%b ready=%b want 0 1 0",
                     cur_m, busy_m, ready_m);
        end
        tgt_valid = 1'b0;
        tick = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (done_m) dcnt++;
        end
        tests++;
        if (cur_m !== 4'd3 || th_m !== 16'h0007 || dcnt !== 1) begin
            fails++;
            $display("FAIL ignore: got cur=%0d th=%h done=%0d want 3 0007 1",
                     cur_m, th_m, dcnt);
        end
    endtask

    task automatic test_reset_mid();
        bit hit;
        sel = 0;
        do_reset();
        tgt_valid = 1'b1;
        tgt_bin = 4'd9;
        tick = 1'b1;
        step();
        tgt_valid = 1'b0;
        hit = 1'b0;
        for (int i = 0; i < 20 && !hit; i++) begin
            step();
            if (cur_m === 4'd3) hit = 1'b1;
        end
        tests++;
        if (!hit) begin
            fails++; $display("FAIL mid_reach: got cur=%0d want 3 within 20 cycles", cur_m);
        end
        rst_n = 1'b0;
        #1;
        tests++;
        if (cur_m !== 4'd0 || th_m !== 16'h0000) begin
            fails++; $display("FAIL mid_rst_cur: got %0d %h want 0 0000", cur_m, th_m);
        end
        tests++;
        if (busy_m !== 1'b0 || done_m !== 1'b0 || ready_m !== 1'b1) begin
            fails++;
            $display("FAIL mid_rst_flags: got %b%b%b want 001", busy_m, done_m, ready_m);
        end
        step();
        rst_n = 1'b1;
        dcnt = 0;
        for (int i = 0; i < 10; i++) begin
            step();
            if (done_m) dcnt++;
        end
        tests++;
        if (dcnt !== 0 || cur_m !== 4'd0) begin
            fails++;
            $display("FAIL mid_after: got done=%0d cur=%0d want 0 0", dcnt, cur_m);
        end
    endtask

`ifdef B2T_SLEW_SETTLE_EN
    task automatic test_settle_abort();
        sel = 0;
        do_reset();
        tgt_valid = 1'b1;
        tgt_bin = 4'd2;
        tick = 1'b1;
        step();
        tgt_valid = 1'b0;
        step();
        step();
        tests++;
        if (cur_m !== 4'd2 || busy_m !== 1'b1 || ready_m !== 1'b1) begin
            fails++;
            $display("FAIL settle_enter: got cur=%0d busy=%b ready=%b want 2 1 1",
                     cur_m, busy_m, ready_m);
        end
        step();
        tgt_valid = 1'b1;
        tgt_bin = 4'd4;
        step();
        tgt_valid = 1'b0;
        tests++;
        if (done_m !== 1'b0 || ready_m !== 1'b0) begin
            fails++;
            $display("FAIL settle_abort: got done=%b ready=%b want 0 0", done_m, ready_m);
        end
        dcnt = 0;
        for (int i = 0; i < 20; i++) begin
            step();
            if (done_m) dcnt++;
        end
        tests++;
        if (dcnt !== 1 || cur_m !== 4'd4 || busy_m !== 1'b0) begin
            fails++;
            $display("FAIL settle_final: got done=%0d cur=%0d busy=%b want 1 4 0",
                     dcnt, cur_m, busy_m);
        end
    endtask
`endif

    initial begin
        test_reset();
        test_step1();
        test_step3();
        test_full_range();
        test_equal_target();
        test_hold_and_ignore();
        test_reset_mid();
`ifdef B2T_SLEW_SETTLE_EN
        test_settle_abort();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
